// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with optional write-to-read bypass
// and a per-register pending scoreboard for RAW hazard detection.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              haz1,
  output logic              haz2,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic BYP = (BYPASS != 0);

  logic [DATA_W-1:0] rf [NREG];
  logic [NREG-1:0]   pend;
  logic [NREG-1:0]   pend_nxt;

  logic wr_v;
  logic rsv_v;
  logic inc;
  logic dec;
  logic byp1;
  logic byp2;

  assign wr_v  = we3 && (wa3 != '0);
  assign rsv_v = rsv_en && (rsv_addr != '0);

  // Set wins over clear when both target the same register.
  always_comb begin
    pend_nxt = pend;
    if (wr_v)
      pend_nxt[wa3] = 1'b0;
    if (rsv_v)
      pend_nxt[rsv_addr] = 1'b1;
  end

  // Count real bit transitions only.
  assign inc = rsv_v && !pend[rsv_addr];
  assign dec = wr_v && pend[wa3]
            && !(rsv_v && (rsv_addr == wa3));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else if (wr_v) begin
      rf[wa3] <= wd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= pend_cnt
                + {{ADDR_W{1'b0}}, inc}
                - {{ADDR_W{1'b0}}, dec};
    end
  end

  assign byp1 = BYP && wr_v && (wa3 == ra1);
  assign byp2 = BYP && wr_v && (wa3 == ra2);

  always_comb begin
    rd1 = byp1 ? wd3 : rf[ra1];
    rd2 = byp2 ? wd3 : rf[ra2];
    if (ra1 == '0)
      rd1 = '0;
    if (ra2 == '0)
      rd2 = '0;
  end

  assign haz1 = pend[ra1] && (ra1 != '0) && !byp1;
  assign haz2 = pend[ra2] && (ra2 != '0) && !byp2;

endmodule
